// File: rtl/circle_stack_pkg.sv
// Shared constants and helpers for the circle stack responder.
package circle_stack_pkg;

    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam int          RD_LAT_MIN = 1;
    localparam int          RD_LAT_MAX = 4;

    function automatic logic [31:0] word_index(input logic [31:0] byte_addr, input int depth_log2);
        return (byte_addr >> 2) & ((32'd1 << depth_log2) - 32'd1);
    endfunction

    function automatic logic lfsr_feedback(input logic [15:0] state);
        return ^(state & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/circle_stack_responder_ram.sv
// Single-port 32-bit word RAM, write-first, registered read data.
module stack_word_ram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   q
);

    logic [31:0] mem_r [0:(1 << AW) - 1];
    logic [31:0] q_r;

    // Storage update and registered read port; a write also lands on q
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_r[addr] <= wdata;
                q_r         <= wdata;
            end else begin
                q_r <= mem_r[addr];
            end
        end
    end

    assign q = q_r;

endmodule

// File: rtl/circle_stack_responder.sv
// Stack-memory responder for the plot coprocessor: fixed-latency pipelined reads,
// host load port, optional stall injection under CIRCLE_STACK_STALL_EN.
module circle_stack_responder #(
    parameter int DATAW        = 18,
    parameter int DEPTH_LOG2   = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             read,
    input  logic             write,
    input  logic [DATAW-1:0] address,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             waitrequest,
    output logic             readdatavalid,
    input  logic             hwrite,
    input  logic [DATAW-1:0] haddress,
    input  logic [31:0]      hwritedata,
    output logic [15:0]      rd_count
);
    import circle_stack_pkg::*;

    localparam int LAT = (READ_LATENCY < RD_LAT_MIN) ? RD_LAT_MIN :
                         (READ_LATENCY > RD_LAT_MAX) ? RD_LAT_MAX : READ_LATENCY;

    logic                  stall_s;
    logic                  waitrequest_s;
    logic                  rd_acc_s;
    logic                  wr_acc_s;
    logic [DATAW-1:0]      sel_addr_s;
    logic [31:0]           sel_wdata_s;
    logic [31:0]           word_s;
    logic [DEPTH_LOG2-1:0] ram_addr_s;
    logic                  ram_we_s;
    logic                  ram_en_s;
    logic [31:0]           ram_q_s;
    logic [31:0]           last_data_s;
    logic [LAT-1:0]        valid_r;
    logic [15:0]           rd_count_r;

`ifdef CIRCLE_STACK_STALL_EN
    logic [15:0] lfsr_r;

    // Free-running stall pattern generator
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= {lfsr_r[14:0], lfsr_feedback(lfsr_r)};
        end
    end

    assign stall_s = (lfsr_r[1:0] == 2'b00);
`else
    assign stall_s = 1'b0;
`endif

    // Back-pressure and acceptance; a read colliding with a write yields to it
    always_comb begin
        waitrequest_s = reset | hwrite | stall_s | (read & write);
        rd_acc_s      = read & ~waitrequest_s;
        wr_acc_s      = write & ~reset & ~hwrite & ~stall_s;
    end

    // Single RAM port arbitration: host load always wins
    always_comb begin
        if (hwrite) begin
            sel_addr_s  = haddress;
            sel_wdata_s = hwritedata;
        end else begin
            sel_addr_s  = address;
            sel_wdata_s = writedata;
        end
        ram_we_s = hwrite | wr_acc_s;
        ram_en_s = ram_we_s | rd_acc_s;
        word_s   = word_index(32'(sel_addr_s), DEPTH_LOG2);
        ram_addr_s = word_s[DEPTH_LOG2-1:0];
    end

    stack_word_ram #(
        .AW (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en_s),
        .we    (ram_we_s),
        .addr  (ram_addr_s),
        .wdata (sel_wdata_s),
        .q     (ram_q_s)
    );

    // Valid shift chain; the RAM output register is stage 1
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= {LAT{1'b0}};
        end else begin
            valid_r[0] <= rd_acc_s;
            for (int i = 1; i < LAT; i++) begin
                valid_r[i] <= valid_r[i-1];
            end
        end
    end

    generate
        if (LAT == 1) begin : g_lat1
            assign last_data_s = ram_q_s;
        end else begin : g_latn
            logic [31:0] dpipe_r [LAT-1];

            // Data stages behind the RAM register
            always_ff @(posedge clk) begin
                dpipe_r[0] <= ram_q_s;
                for (int i = 1; i < LAT - 1; i++) begin
                    dpipe_r[i] <= dpipe_r[i-1];
                end
            end

            assign last_data_s = dpipe_r[LAT-2];
        end
    endgenerate

    // Saturating accepted-read counter
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count_r <= 16'h0000;
        end else if (rd_acc_s && (rd_count_r != 16'hFFFF)) begin
            rd_count_r <= rd_count_r + 16'h0001;
        end
    end

    assign waitrequest   = waitrequest_s;
    assign readdatavalid = valid_r[LAT-1];
    assign readdata      = valid_r[LAT-1] ? last_data_s : 32'h0000_0000;
    assign rd_count      = rd_count_r;

endmodule

// File: tb/tb_circle_stack_responder.sv
// Directed self-checking bench for circle_stack_responder.
module tb_circle_stack_responder;

    logic        clk;
    logic        reset;
    logic        read;
    logic        write;
    logic [17:0] address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        readdatavalid;
    logic        hwrite;
    logic [17:0] haddress;
    logic [31:0] hwritedata;
    logic [15:0] rd_count;

    int total = 0;
    int bad   = 0;

    circle_stack_responder #(
        .DATAW        (18),
        .DEPTH_LOG2   (10),
        .READ_LATENCY (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .read          (read),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .waitrequest   (waitrequest),
        .readdatavalid (readdatavalid),
        .hwrite        (hwrite),
        .haddress      (haddress),
        .hwritedata    (hwritedata),
        .rd_count      (rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: check outputs mid-cycle, then advance past the next rising edge
    task automatic cyc(input logic ev, input logic [31:0] ed, input logic ew, input string tag);
        @(negedge clk);
        chk({tag, "_valid"}, {31'd0, readdatavalid}, {31'd0, ev});
        chk({tag, "_data"}, readdata, ed);
        chk({tag, "_wait"}, {31'd0, waitrequest}, {31'd0, ew});
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sval(input int i);
        return 32'h0000_1000 + 32'(i * 3);
    endfunction

    initial begin
        int          n_reads;
        int          issued;
        int          cycles;
        int          stalls;
        int          rd_cycles;
        logic        acc;
        logic [31:0] exp_q[$];

        reset = 1'b1; read = 1'b0; write = 1'b0; address = 18'd0; writedata = 32'd0;
        hwrite = 1'b0; haddress = 18'd0; hwritedata = 32'd0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_wait", {31'd0, waitrequest}, 32'd1);
        chk("rst_valid", {31'd0, readdatavalid}, 32'd0);
        chk("rst_data", readdata, 32'd0);
        chk("rst_count", {16'd0, rd_count}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

`ifndef CIRCLE_STACK_STALL_EN
        // Host load then back-to-back reads
        hwrite = 1'b1; haddress = 18'h0; hwritedata = 32'd5; cyc(1'b0, 32'd0, 1'b1, "ld0");
        haddress = 18'h4; hwritedata = 32'd7; cyc(1'b0, 32'd0, 1'b1, "ld1");
        haddress = 18'h8; hwritedata = 32'd9; cyc(1'b0, 32'd0, 1'b1, "ld2");
        hwrite = 1'b0;
        read = 1'b1; address = 18'h0; cyc(1'b0, 32'd0, 1'b0, "b2b0");
        address = 18'h4; cyc(1'b0, 32'd0, 1'b0, "b2b1");
        address = 18'h8; cyc(1'b1, 32'd5, 1'b0, "b2b2");
        read = 1'b0; cyc(1'b1, 32'd7, 1'b0, "b2b3");
        cyc(1'b1, 32'd9, 1'b0, "b2b4");
        cyc(1'b0, 32'd0, 1'b0, "b2b5");
        chk("cnt_b2b", {16'd0, rd_count}, 32'd3);

        // Coprocessor write then read-after-write
        write = 1'b1; address = 18'h10; writedata = 32'hDEAD; cyc(1'b0, 32'd0, 1'b0, "wr0");
        write = 1'b0; read = 1'b1; cyc(1'b0, 32'd0, 1'b0, "wr1");
        read = 1'b0; cyc(1'b0, 32'd0, 1'b0, "wr2");
        cyc(1'b1, 32'hDEAD, 1'b0, "wr3");
        chk("cnt_wr", {16'd0, rd_count}, 32'd4);

        // Host load collides with a read of the same word
        read = 1'b1; address = 18'hC; hwrite = 1'b1; haddress = 18'hC; hwritedata = 32'h55;
        cyc(1'b0, 32'd0, 1'b1, "hc0");
        hwrite = 1'b0; cyc(1'b0, 32'd0, 1'b0, "hc1");
        read = 1'b0; cyc(1'b0, 32'd0, 1'b0, "hc2");
        cyc(1'b1, 32'h55, 1'b0, "hc3");
        chk("cnt_hc", {16'd0, rd_count}, 32'd5);

        // Upper address bits alias onto word 0
        hwrite = 1'b1; haddress = 18'h0; hwritedata = 32'h11; cyc(1'b0, 32'd0, 1'b1, "al_ld");
        hwrite = 1'b0; read = 1'b1; address = 18'h1000; cyc(1'b0, 32'd0, 1'b0, "al0");
        read = 1'b0; cyc(1'b0, 32'd0, 1'b0, "al1");
        cyc(1'b1, 32'h11, 1'b0, "al2");

        // Read and write together: write goes first, read retries
        read = 1'b1; write = 1'b1; address = 18'h20; writedata = 32'h77;
        cyc(1'b0, 32'd0, 1'b1, "rw0");
        write = 1'b0; cyc(1'b0, 32'd0, 1'b0, "rw1");
        read = 1'b0; cyc(1'b0, 32'd0, 1'b0, "rw2");
        cyc(1'b1, 32'h77, 1'b0, "rw3");
        chk("cnt_rw", {16'd0, rd_count}, 32'd7);

        // Last word followed by the next word wraps to word 0
        hwrite = 1'b1; haddress = 18'hFFC; hwritedata = 32'hABC; cyc(1'b0, 32'd0, 1'b1, "wp_ld");
        hwrite = 1'b0; read = 1'b1; address = 18'hFFC; cyc(1'b0, 32'd0, 1'b0, "wp0");
        address = 18'h1000; cyc(1'b0, 32'd0, 1'b0, "wp1");
        read = 1'b0; cyc(1'b1, 32'hABC, 1'b0, "wp2");
        cyc(1'b1, 32'h11, 1'b0, "wp3");
        cyc(1'b0, 32'd0, 1'b0, "wp4");
        chk("cnt_wp", {16'd0, rd_count}, 32'd9);

        // Reset with reads in flight
        read = 1'b1; address = 18'h0; cyc(1'b0, 32'd0, 1'b0, "rs0");
        address = 18'h4; cyc(1'b0, 32'd0, 1'b0, "rs1");
        read = 1'b0; reset = 1'b1; cyc(1'b1, 32'h11, 1'b1, "rs2");
        reset = 1'b0; cyc(1'b0, 32'd0, 1'b0, "rs3");
        cyc(1'b0, 32'd0, 1'b0, "rs4");
        chk("cnt_rs", {16'd0, rd_count}, 32'd0);
        n_reads = 16;
`else
        n_reads = 1000;
`endif

        // Streaming reads against a scoreboard
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            hwrite = 1'b1; haddress = 18'(i * 4); hwritedata = sval(i);
            @(posedge clk);
            #1;
        end
        hwrite = 1'b0;
        issued = 0; cycles = 0; stalls = 0; rd_cycles = 0;
        while ((issued < n_reads || exp_q.size() > 0) && cycles < 5000) begin
            read = (issued < n_reads);
            address = 18'((issued % 16) * 4);
            @(negedge clk);
            if (readdatavalid) begin
                if (exp_q.size() == 0) chk("st_extra", 32'd1, 32'd0);
                else chk("st_data", readdata, exp_q.pop_front());
            end
            if (read) rd_cycles++;
            if (read && waitrequest) stalls++;
            acc = read && !waitrequest;
            @(posedge clk);
            #1;
            if (acc) begin
                exp_q.push_back(sval(issued % 16));
                issued++;
            end
            cycles++;
        end
        read = 1'b0;
        chk("st_timeout", {31'd0, cycles < 5000}, 32'd1);
        chk("st_count", {16'd0, rd_count}, 32'(n_reads));
`ifdef CIRCLE_STACK_STALL_EN
        chk("st_stall_lo", {31'd0, stalls * 100 >= rd_cycles * 20}, 32'd1);
        chk("st_stall_hi", {31'd0, stalls * 100 <= rd_cycles * 30}, 32'd1);
`else
        chk("st_nostall", 32'(stalls), 32'd0);
        chk("st_cycles", 32'(cycles), 32'(n_reads + 2));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/circle_stack_responder.md
# circle_stack_responder

Memory-mapped responder sitting on the far end of the plot coprocessor's stack-memory master port. It holds the x/y/r parameter arrays in a local word store and serves the coprocessor's pipelined reads with fixed latency, `waitrequest` back-pressure and `readdatavalid` strobes. It also accepts coprocessor writes and a host-side load port for filling the arrays before a `writestart`.

## Interface

Parameters:
- `DATAW`, 18: byte-address width of the responder port; matches the coprocessor master `maddress`.
- `DEPTH_LOG2`, 10: log2 of the number of 32-bit words stored.
- `READ_LATENCY`, 2: cycles from read acceptance to `readdatavalid`; legal range 1..4.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `read` in 1: read request from the coprocessor.
- `write` in 1: write request from the coprocessor.
- `address` in DATAW: byte address; word index is `address[DEPTH_LOG2+1:2]`, and the upper bits alias.
- `writedata` in 32: coprocessor write data.
- `readdata` out 32: read data; forced to 0 when `readdatavalid` is low.
- `waitrequest` out 1: the request is not accepted this cycle.
- `readdatavalid` out 1: one-cycle strobe qualifying `readdata`.
- `hwrite` in 1: host load strobe; never stalled.
- `haddress` in DATAW: host byte address, with the same word mapping as `address`.
- `hwritedata` in 32: host load data.
- `rd_count` out 16: saturating count of reads accepted since reset.

## Operation

- **Acceptance**
  - A request is accepted on a rising edge with (`read` | `write`) & ~`waitrequest`.
  - The coprocessor holds `read`/`write`/`address`/`writedata` stable while `waitrequest` is high.
- **waitrequest sources (combinational)**
  - `hwrite` high.
  - Injected stall (see Configuration).
  - `read` & `write` in the same cycle: the write is accepted and `waitrequest` is asserted for the read. The read then retries on the next cycle.
  - `waitrequest` never depends on pipeline occupancy. The pipeline accepts one read per cycle indefinitely.
- **Host load**
  - `hwrite` writes `hwritedata` to the word in the same cycle and always wins the single RAM port.
- **Writes**
  - Write-first semantics. A read accepted the cycle after a write to the same word returns the new data.
- **Read pipeline**
  - The RAM registers the read at acceptance (stage 1).
  - `READ_LATENCY-1` further data/valid register stages follow.
  - In-order, no reordering, no drop.
- **`rd_count`**
  - +1 per accepted read; sticks at 16'hFFFF.
- **Reset**
  - Clears all pipeline valid bits, `rd_count` and the stall LFSR.
  - RAM contents are not cleared.
  - Reads in flight at reset never produce `readdatavalid`.
  - During reset, `waitrequest` = 1.
- **Reset values**
  - `readdata` = 0, `readdatavalid` = 0, `rd_count` = 0, `waitrequest` = 1.

## Timing

- A read accepted at edge N gives `readdatavalid` = 1 in the cycle after edge N+`READ_LATENCY`-1.
  - Default: data appears two cycles after the accepting cycle.
- Back-to-back reads on consecutive cycles give consecutive valid strobes at full throughput.
  - The coprocessor X/Y/R sequence (3 reads, 4 cycles per circle) is served with no stalls when injection is off.
- Writes have no response and complete at the accepting edge.
- A host load at word W on the same cycle as a coprocessor read of W: the read is stalled and returns the host data on retry.
- Address wrap: word index DEPTH-1 followed by +4 maps to word 0 (aliasing). There is no error response.

## Configuration

- `CIRCLE_STACK_STALL_EN` defined:
  - A 16-bit Fibonacci LFSR advances every cycle out of reset. Taps: bits 16,14,13,11. Seed 16'hACE1.
  - An extra `waitrequest` is asserted when `lfsr[1:0]` == 2'b00, giving about 25% stall cycles to stress the master's hold behaviour.
- Not defined:
  - No LFSR logic.
  - `waitrequest` comes from `hwrite`, the read/write collision, and reset only.

## Structure

- Package `circle_stack_pkg` holds:
  - LFSR seed and tap mask constants.
  - The `READ_LATENCY` legal-range constants.
  - A word-index function mapping a byte address to `[DEPTH_LOG2-1:0]`.
- One sub-module, `stack_word_ram`: single-port 32-bit RAM with write-first behaviour and a registered output. The arbitration mux (host vs coprocessor) stays in the top.

## Test plan

- Host-load words 0..2 with 5, 7, 9, then read byte addresses 0, 4, 8 back-to-back -> `readdatavalid` on 3 consecutive cycles, latency 2, data 5, 7, 9.
- Write 32'hDEAD to byte address 0x10, then read 0x10 on the next cycle -> returns 32'hDEAD.
- `hwrite` on the same cycle as a read of word 3 (host data 0x55) -> `waitrequest` = 1 for one cycle, and the retried read returns 0x55.
- Assert `reset` with 2 reads in flight -> no `readdatavalid` afterwards, and `rd_count` = 0.
- With `DEPTH_LOG2`=10, read byte address 0x1000 after loading word 0 with 0x11 -> returns 0x11 (alias).
- With `CIRCLE_STACK_STALL_EN` defined, issue 1000 reads -> stall cycles within 20–30%, every read returns correct data in order, and `rd_count` = 1000.
